mdu_unit: RTL

Multi-cycle multiply/divide unit in the execute stage, beside the ALU. It is fed by the same D/E-latched, forwarded operand pair (num1, num2). It owns the architectural HI/LO registers and their results feed the E-stage result mux for MFHI/MFLO. It raises a stall request so the hazard unit freezes D/E while an operation is in flight.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_core_arith.sv | 74 +++++++
 rtl/mdu_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared decode constants for the execute stage: ALU and MDU operation codes
// plus the default multi-cycle latencies of the multiply/divide unit.
package mdu_pkg;

    // ALU operation codes sharing the same 8-bit op field
    localparam logic [7:0] ALU_ADD   = 8'h01;
    localparam logic [7:0] ALU_SUB   = 8'h02;
    localparam logic [7:0] ALU_AND   = 8'h03;
    localparam logic [7:0] ALU_OR    = 8'h04;

    // Multiply/divide unit operation codes
    localparam logic [7:0] MDU_NOP   = 8'h00;
    localparam logic [7:0] MDU_MULT  = 8'h21;
    localparam logic [7:0] MDU_MULTU = 8'h22;
    localparam logic [7:0] MDU_DIV   = 8'h23;
    localparam logic [7:0] MDU_DIVU  = 8'h24;
    localparam logic [7:0] MDU_MTHI  = 8'h25;
    localparam logic [7:0] MDU_MTLO  = 8'h26;

    // Default busy periods
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    // True for the operations that occupy the unit for several cycles
    function automatic logic is_muldiv(input logic [7:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core_arith.sv
// Combinational arithmetic core: 64-bit product or quotient/remainder pair
// from the latched operands. Division runs on magnitudes and the signs are
// restored afterwards (quotient truncates toward zero, remainder follows the
// dividend). A zero divisor is replaced by one to keep the divider defined;
// the flag tells the top not to commit the result.
module mdu_core_arith
    import mdu_pkg::*;
(
    input  logic [7:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_zero
);

    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic               w_signed_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic        [31:0] w_mag_a;
    logic        [31:0] w_mag_b;
    logic        [31:0] w_den;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;
    logic        [31:0] w_q;
    logic        [31:0] w_r;
    logic               w_b_zero;

    assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

    assign w_signed_div = (i_op == MDU_DIV);
    assign w_a_neg      = w_signed_div & i_a[31];
    assign w_b_neg      = w_signed_div & i_b[31];
    // Negating 0x80000000 yields 0x80000000, which is the correct magnitude
    // when read as unsigned.
    assign w_mag_a      = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_mag_b      = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_b_zero     = (i_b == 32'd0);
    assign w_den        = w_b_zero ? 32'd1 : w_mag_b;
    assign w_uq         = w_mag_a / w_den;
    assign w_ur         = w_mag_a % w_den;
    assign w_q          = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
    assign w_r          = w_a_neg ? (32'd0 - w_ur) : w_ur;

    // Select the HI/LO pair for the requested operation
    always_comb begin
        o_hi       = 32'd0;
        o_lo       = 32'd0;
        o_div_zero = 1'b0;
        case (i_op)
            MDU_MULT: begin
                o_hi = w_sprod[63:32];
                o_lo = w_sprod[31:0];
            end
            MDU_MULTU: begin
                o_hi = w_uprod[63:32];
                o_lo = w_uprod[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                o_hi       = w_r;
                o_lo       = w_q;
                o_div_zero = w_b_zero;
            end
            default: begin
                o_hi = 32'd0;
                o_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit. Owns architectural HI/LO. A down
// counter is the run state: non-zero means an operation is in flight, and
// the 1->0 step is the commit edge. MTHI/MTLO write directly when idle.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  mdu_op,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             w_busy;
    logic             w_is_md;
    logic             w_accept;
    logic             w_done;
    logic             w_is_mul;
    logic             w_idle_start;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;

    assign w_busy       = (r_cnt != '0);
    assign w_idle_start = start & ~w_busy;
    assign w_is_md      = start & is_muldiv(mdu_op);
    assign w_accept     = w_is_md & ~w_busy;
    assign w_is_mul     = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
    assign w_done       = (r_cnt == CNT_W'(1));

    mdu_core_arith u_core (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_hi       (w_res_hi),
        .o_lo       (w_res_lo),
        .o_div_zero (w_div_zero)
    );

    // State register: busy counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Next state: load on accept, count down while running
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_busy) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_accept) begin
            w_cnt_nxt = w_is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
        end
    end

    // Outputs: busy from the counter, stall also covers the issue cycle
    always_comb begin
        busy      = w_busy;
        stall_req = w_busy | w_is_md;
        hi_out    = r_hi;
        lo_out    = r_lo;
    end

    // Capture op and operands so live operand changes cannot disturb a run
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op <= 8'd0;
            r_a  <= 32'd0;
            r_b  <= 32'd0;
        end else if (w_accept) begin
            r_op <= mdu_op;
            r_a  <= num1;
            r_b  <= num2;
        end
    end

    // HI/LO update: commit on the final run edge, or direct move when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            if (!w_div_zero) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (w_idle_start && (mdu_op == MDU_MTHI)) begin
            r_hi <= num1;
        end else if (w_idle_start && (mdu_op == MDU_MTLO)) begin
            r_lo <= num1;
        end
    end

endmodule
